mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_array.sv | 33 +++
 rtl/mem_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory responder.
package mem_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_ERROR = 4'b1000
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> responder strobe/data bundle.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              oe;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output oe, we, addr, wdata,
    input  rdata, rvalid, ack, err, busy
  );

  modport slave (
    input  oe, we, addr, wdata,
    output rdata, rvalid, ack, err, busy
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous write, registered read, synchronous active-low clear.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear has priority so a strobe coincident with reset never commits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Strobe-driven memory responder: single writes and wrapping read bursts.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for oe or we
  // READ  | burst in progress, one word per oe cycle
  // WRITE | one-cycle write acknowledge
  // ERROR | protocol violation, held until both strobes drop

  // Burst wraps within an aligned group, so BURST_LEN must be >= 2 and < 2**ADDR_W.
  localparam int LOW_W  = $clog2(BURST_LEN);
  localparam int BEAT_W = LOW_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [LOW_W-1:0]  low_sum;
  logic              rvalid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      base     <= '0;
      beat     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      beat     <= beat_nxt;
      rvalid_q <= rd_en;
    end
  end

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    beat_nxt  = beat;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    rd_addr   = base;
    low_sum   = base[LOW_W-1:0] + beat[LOW_W-1:0];
    unique case (state)
      ST_IDLE: begin
        if (bus.oe && bus.we) begin
          state_nxt = ST_ERROR;
        end else if (bus.oe) begin
          state_nxt = ST_READ;
          base_nxt  = bus.addr;
          beat_nxt  = BEAT_W'(1);
          rd_en     = 1'b1;
          rd_addr   = bus.addr;
        end else if (bus.we) begin
          state_nxt = ST_WRITE;
          wr_en     = 1'b1;
        end
      end
      ST_READ: begin
        if (bus.we) begin
          state_nxt = ST_ERROR;
        end else if (bus.oe) begin
          if (beat == BEAT_W'(BURST_LEN)) begin
            state_nxt = ST_ERROR;
          end else begin
            rd_en    = 1'b1;
            rd_addr  = {base[ADDR_W-1:LOW_W], low_sum};
            beat_nxt = beat + BEAT_W'(1);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_ERROR: begin
        if (!bus.oe && !bus.we) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(bus.addr),
    .wr_data(bus.wdata),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(bus.rdata)
  );

  assign bus.rvalid = rvalid_q;
  assign bus.ack    = (state == ST_WRITE);
  assign bus.err    = (state == ST_ERROR);
  assign bus.busy   = (state != ST_IDLE);

endmodule
